// File: rtl/bcd2bin_pkg.sv
// Shared constants for the BCD <-> binary conversion paths.
//   state_t     : converter FSM encodings (IDLE / CONV / DONE)
//   BCD_W       : bits per BCD digit
//   DEF_DIGITS  : default digit count on the BCD side
//   DEF_BIN_W   : default binary width (2^DEF_BIN_W > 10^DEF_DIGITS - 1)
package bcd2bin_pkg;

  localparam int BCD_W      = 4;
  localparam int DEF_DIGITS = 3;
  localparam int DEF_BIN_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd2bin_seq_digit_adj.sv
// bcd_digit_adj: per-digit correction step of reverse double-dabble.
//   i_d : 4-bit digit after the right shift
//   o_d : i_d - 3 when i_d >= 8, else i_d (never underflows, 8-3 = 5)
module bcd_digit_adj (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);

  assign o_d = (i_d >= 4'd8) ? (i_d - 4'd3) : i_d;

endmodule

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential BCD-to-binary converter (reverse double-dabble,
// one shift/correct iteration per clock).
//   clk     : rising-edge clock
//   reset   : synchronous, active-high
//   start   : request, sampled only while ready=1
//   bcd_in  : packed BCD, digit 0 in [3:0], captured on accepted start
//   ready   : idle, able to accept start
//   done    : one-cycle pulse, bin_out/err valid
//   err     : captured word contained a digit > 9
//   bin_out : binary result, held until the next accepted start completes
module bcd2bin_seq
  import bcd2bin_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BIN_W  = DEF_BIN_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BCD_W*DIGITS-1:0] bcd_in,
  output logic                    ready,
  output logic                    done,
  output logic                    err,
  output logic [BIN_W-1:0]        bin_out
);

  localparam int BCD_TOT = BCD_W * DIGITS;
  localparam int SR_W    = BCD_TOT + BIN_W;
  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(BIN_W - 1);

  state_t            r_state;
  logic [SR_W-1:0]   r_sr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic [BIN_W-1:0]  r_bin;

  logic [SR_W-1:0]   w_shr;
  logic [SR_W-1:0]   w_sr_nxt;
  logic [DIGITS-1:0] w_dig_bad;

  // Shift the whole {bcd,bin} register right, then correct each BCD digit.
  assign w_shr                  = r_sr >> 1;
  assign w_sr_nxt[BIN_W-1:0]    = w_shr[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_adj u_adj (
      .i_d (w_shr[BIN_W + g*BCD_W +: BCD_W]),
      .o_d (w_sr_nxt[BIN_W + g*BCD_W +: BCD_W])
    );
    assign w_dig_bad[g] = (bcd_in[g*BCD_W +: BCD_W] > 4'd9);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_bin   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sr  <= {bcd_in, {BIN_W{1'b0}}};
            r_cnt <= '0;
            if (|w_dig_bad) begin
              // Non-BCD input skips conversion entirely.
              r_err   <= 1'b1;
              r_bin   <= '0;
              r_state <= ST_DONE;
            end else begin
              r_err   <= 1'b0;
              r_state <= ST_CONV;
            end
          end
        end
        ST_CONV: begin
          r_sr  <= w_sr_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_IT) begin
            r_bin   <= w_sr_nxt[BIN_W-1:0];
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready   = (r_state == ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign err     = r_err;
  assign bin_out = r_bin;

endmodule

// File: tb/tb_bcd2bin_seq.sv
module tb_bcd2bin_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] bcd_in;
  logic        ready;
  logic        done;
  logic        err;
  logic [9:0]  bin_out;

  int vectors = 0;
  int misc    = 0;

  bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bcd_in  (bcd_in),
    .ready   (ready),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (edge-count timeline) ----------------
  int   cyc          = 0;
  int   m_ready_edge = 0;   // ready is high after every edge >= this
  int   m_done_edge  = -1;  // done is high right after this edge
  int   m_bin        = 0;
  bit   m_err        = 0;
  int   m_pbin       = 0;
  bit   m_perr       = 0;
  bit   chk_en       = 0;

  always @(posedge clk) begin
    int d2, d1, d0;
    cyc++;
    if (reset) begin
      m_ready_edge = cyc;
      m_done_edge  = -1;
      m_bin        = 0;
      m_err        = 0;
      chk_en       = 1;
    end else if (chk_en) begin
      if (start && (cyc - 1 >= m_ready_edge)) begin
        d2 = int'(bcd_in[11:8]); d1 = int'(bcd_in[7:4]); d0 = int'(bcd_in[3:0]);
        m_perr = (d2 > 9) || (d1 > 9) || (d0 > 9);
        m_pbin = m_perr ? 0 : d2*100 + d1*10 + d0;
        m_done_edge  = cyc + (m_perr ? 0 : BIN_W);
        m_ready_edge = m_done_edge + 1;
      end
      if (cyc == m_done_edge) begin
        m_bin = m_pbin;
        m_err = m_perr;
      end
    end
  end

  always @(negedge clk) begin
    bit er, ed;
    if (chk_en) begin
      er = (cyc >= m_ready_edge);
      ed = (cyc == m_done_edge);
      check("ready", 32'(ready), 32'(er));
      check("done",  32'(done),  32'(ed));
      if (er || ed) begin
        check("bin_out", 32'(bin_out), 32'(m_bin));
        check("err",     32'(err),     32'(m_err));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Wait for done after the accept edge already passed; lat counts edges from accept.
  task automatic wait_done(input int first, output int lat);
    lat = 0;
    if (done) lat = first;
    else begin
      for (int i = first + 1; i <= 40; i++) begin
        tick;
        if (done) begin lat = i; break; end
      end
    end
  endtask

  task automatic do_conv(input logic [11:0] b, input int exp_bin, input bit exp_err,
                         input int exp_lat);
    int lat;
    bcd_in = b; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(1, lat);
    check("latency", 32'(lat), 32'(exp_lat));
    if (lat > 0) begin
      check("lit_bin", 32'(bin_out), 32'(exp_bin));
      check("lit_err", 32'(err), 32'(exp_err));
    end
    tick;
  endtask

  task automatic wait_ready;
    for (int i = 0; i < 40 && !ready; i++) tick;
    check("ready_timeout", 32'(ready), 32'd1);
  endtask

  initial begin
    int lat, npulse, last;
    logic [11:0] b;
    reset = 1'b1; start = 1'b0; bcd_in = '0;
    tick; tick;
    reset = 1'b0;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done",  32'(done),  32'd0);
    check("rst_err",   32'(err),   32'd0);
    check("rst_bin",   32'(bin_out), 32'd0);

    do_conv(12'h009, 9, 0, 11);
    do_conv(12'h099, 99, 0, 11);
    do_conv(12'h100, 100, 0, 11);
    do_conv(12'h999, 999, 0, 11);
    do_conv(12'h000, 0, 0, 11);
    do_conv(12'h0A5, 0, 1, 1);
    check("err_ready_back", 32'(ready), 32'd1);
    do_conv(12'h042, 42, 0, 11);   // err clears on a good word

    // start while busy is ignored
    bcd_in = 12'h123; start = 1'b1; tick; start = 1'b0;
    tick; tick; tick;
    bcd_in = 12'h456; start = 1'b1; tick; start = 1'b0; bcd_in = 12'h777;
    wait_done(5, lat);
    check("ign_latency", 32'(lat), 32'd11);
    check("ign_bin", 32'(bin_out), 32'd123);
    tick;

    // reset mid-conversion aborts
    bcd_in = 12'h555; start = 1'b1; tick; start = 1'b0;
    tick; tick; tick; tick;
    reset = 1'b1; tick; reset = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_bin",   32'(bin_out), 32'd0);
    npulse = 0;
    for (int i = 0; i < 15; i++) begin tick; if (done) npulse++; end
    check("abort_nodone", 32'(npulse), 32'd0);
    do_conv(12'h042, 42, 0, 11);

    // start held high: accept every BIN_W+2 cycles
    bcd_in = 12'h010; start = 1'b1;
    npulse = 0; last = -1;
    for (int i = 0; i < 50; i++) begin
      tick;
      if (done) begin
        if (last >= 0) check("b2b_period", 32'(i - last), 32'(BIN_W + 2));
        check("b2b_bin", 32'(bin_out), 32'd10);
        last = i; npulse++;
      end
    end
    start = 1'b0;
    check("b2b_pulses", 32'(npulse), 32'd4);
    wait_ready;

    // exhaustive valid sweep against decimal value
    for (int v = 0; v < 1000; v++) begin
      b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      do_conv(b, v, 0, 11);
    end

    // random start/data/reset traffic, checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      start = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0)
        bcd_in = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else
        bcd_in = 12'($urandom);
      tick;
    end
    reset = 1'b0; start = 1'b0;
    wait_ready;
    tick; tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
